// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone responder over a DEPTH x 32-bit register memory with byte-lane
// writes, fixed response latency, address-range error and external back-pressure.
module wb_mem_responder #(
    parameter int          DEPTH    = 16,
    parameter int          LATENCY  = 2,
    parameter logic [31:0] BASE_TAG = 32'h0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        cyc,
    input  logic        stb__ENA,
    input  logic        stb_we,
    input  logic [31:0] stb_addr,
    input  logic [31:0] stb_data,
    input  logic [3:0]  stb_sel,
    output logic        stb__RDY,
    input  logic        busy,
    output logic        ack,
    output logic        err,
    output logic [31:0] data,
    output logic        ack__RDY,
    output logic        stall__RDY,
    output logic        err__RDY,
    output logic        stall,
    output logic [2:0]  outstanding
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = 30 - AW;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("wb_mem_responder: LATENCY must be in 1..4");
    end
    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_mem_responder: DEPTH must be a power of two in 2..256");
    end

    logic          accept;
    logic          hit;
    logic [AW-1:0] idx;
    logic [TW-1:0] tag;
    logic          unused_addr;

    logic [31:0]        mem_q     [DEPTH];
    logic [31:0]        mem_d     [DEPTH];
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] iserr_q, iserr_d;
    logic [31:0]        rdata_q   [LATENCY];
    logic [31:0]        rdata_d   [LATENCY];
    logic [2:0]         outstanding_q, outstanding_d;
    logic               retire;

    assign tag         = stb_addr[31:AW+2];
    assign idx         = stb_addr[AW+1:2];
    assign unused_addr = ^stb_addr[1:0];
    assign hit         = (tag == BASE_TAG[TW-1:0]);

    // Back-pressure is purely combinational so busy acts in the same cycle.
    assign stall      = busy;
    assign stb__RDY   = !busy;
    assign ack__RDY   = 1'b1;
    assign stall__RDY = 1'b1;
    assign err__RDY   = 1'b1;

    assign accept = cyc && stb__ENA && !busy;
    assign retire = vld_q[LATENCY-1];

    always_comb begin
        mem_d = mem_q;
        if (accept && hit && stb_we) begin
            for (int b = 0; b < 4; b++) begin
                if (stb_sel[b]) begin
                    mem_d[idx][8*b +: 8] = stb_data[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 loads at accept; higher stages shift one per cycle.
    // Dropping cyc kills every in-flight response.
    always_comb begin
        vld_d   = vld_q;
        iserr_d = iserr_q;
        rdata_d = rdata_q;
        for (int i = LATENCY - 1; i > 0; i--) begin
            iserr_d[i] = iserr_q[i-1];
            rdata_d[i] = rdata_q[i-1];
        end
        iserr_d[0] = !hit;
        rdata_d[0] = (accept && hit && !stb_we) ? mem_q[idx] : 32'h0;
        if (!cyc) begin
            vld_d = '0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                vld_d[i] = vld_q[i-1];
            end
            vld_d[0] = accept;
        end
    end

    always_comb begin
        if (!cyc) begin
            outstanding_d = 3'd0;
        end else begin
            outstanding_d = outstanding_q + 3'(accept) - 3'(retire);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            vld_q         <= '0;
            iserr_q       <= '0;
            outstanding_q <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else begin
            vld_q         <= vld_d;
            iserr_q       <= iserr_d;
            outstanding_q <= outstanding_d;
            mem_q         <= mem_d;
        end
    end

    // Read data needs no reset: it is only visible while a valid ack is presented.
    always_ff @(posedge CLK) begin
        rdata_q <= rdata_d;
    end

    assign ack         = vld_q[LATENCY-1] && !iserr_q[LATENCY-1] && cyc;
    assign err         = vld_q[LATENCY-1] && iserr_q[LATENCY-1] && cyc;
    assign data        = ack ? rdata_q[LATENCY-1] : 32'h0;
    assign outstanding = outstanding_q;

endmodule
